// File: rtl/k_apply_alu.sv
// k_apply_alu: Kalman measurement-update stage.
// Waits for a rising edge on the gain divider's done level, captures the gains,
// the innovation and the prior state, then forms x_post = x_prior + K*innov for
// both EKF states on one shared signed multiplier. The saturated posterior is
// presented with a one-cycle completion pulse.
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   div_done            divider done level; its rising edge starts an update
//   k_1, k_2            gains, Q3.20 / Q0.23
//   innov               innovation v_meas - v_pred, Q3.20
//   x1_prior, x2_prior  prior RC voltage (Q3.20) and SOC (Q0.23)
//   x1_post, x2_post    posterior state, held until the next update
//   busy                high from capture through the upd_done cycle
//   upd_done            one-cycle pulse, posterior updated this cycle
//   ovr                 one-cycle pulse, a start edge arrived while busy and was dropped
module k_apply_alu #(
   parameter int unsigned DW      = 24,
   parameter int unsigned K1_FRAC = 20,
   parameter int unsigned K2_FRAC = 23,
   parameter int unsigned E_FRAC  = 20,
   parameter logic [DW-1:0] SOC_MAX = DW'((64'd1 << K2_FRAC) - 64'd1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          div_done,
   input  logic [DW-1:0] k_1,
   input  logic [DW-1:0] k_2,
   input  logic [DW-1:0] innov,
   input  logic [DW-1:0] x1_prior,
   input  logic [DW-1:0] x2_prior,
   output logic [DW-1:0] x1_post,
   output logic [DW-1:0] x2_post,
   output logic          busy,
   output logic          upd_done,
   output logic          ovr
);

   localparam int unsigned PW = 2 * DW;   // product width
   localparam int unsigned SW = PW + 1;   // accumulate width

   localparam logic signed [SW-1:0] X1_MAX    = $signed({{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}});
   localparam logic signed [SW-1:0] X1_MIN    = $signed({{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}});
   localparam logic signed [SW-1:0] SOC_MAX_X = $signed({{(SW-DW){1'b0}}, SOC_MAX});

   typedef enum logic [2:0] {
      S_IDLE, S_MUL1, S_ACC1, S_MUL2, S_ACC2, S_DONE
   } state_t;

   state_t               state_q;
   logic                 div_done_q;
   logic signed [DW-1:0] k1_q, k2_q, innov_q, x1_q, x2_q;
   logic signed [PW-1:0] prod_q;
   logic        [DW-1:0] x1_tmp_q, x2_tmp_q;

   logic                 start;
   logic signed [DW-1:0] mul_a;
   logic signed [PW-1:0] mul_a_x, innov_x, prod_d;
   logic signed [PW-1:0] p_sh1, p_sh2;
   logic signed [SW-1:0] sum1, sum2;
   logic        [DW-1:0] x1_sat, x2_sat;

   assign start = div_done & ~div_done_q;

   // Shared multiplier: gain for the lane currently in its MUL state.
   assign mul_a   = (state_q == S_MUL2) ? k2_q : k1_q;
   assign mul_a_x = PW'(mul_a);
   assign innov_x = PW'(innov_q);
   assign prod_d  = mul_a_x * innov_x;

   // Q3.20*Q3.20 -> Q.40 and Q0.23*Q3.20 -> Q.43; both shift back by the innovation scale.
   assign p_sh1 = prod_q >>> K1_FRAC;
   assign p_sh2 = prod_q >>> E_FRAC;
   assign sum1  = SW'(x1_q) + SW'(p_sh1);
   assign sum2  = SW'(x2_q) + SW'(p_sh2);

   // x1 saturates to the signed Q3.20 range.
   always_comb begin
      x1_sat = sum1[DW-1:0];
      if (sum1 > X1_MAX)      x1_sat = {1'b0, {(DW-1){1'b1}}};
      else if (sum1 < X1_MIN) x1_sat = {1'b1, {(DW-1){1'b0}}};
   end

   // SOC clamps to [0, SOC_MAX].
   always_comb begin
      x2_sat = sum2[DW-1:0];
      if (sum2[SW-1])            x2_sat = '0;
      else if (sum2 > SOC_MAX_X) x2_sat = SOC_MAX;
   end

   // Sequencer, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         div_done_q <= 1'b0;
         k1_q       <= '0;
         k2_q       <= '0;
         innov_q    <= '0;
         x1_q       <= '0;
         x2_q       <= '0;
         prod_q     <= '0;
         x1_tmp_q   <= '0;
         x2_tmp_q   <= '0;
         x1_post    <= '0;
         x2_post    <= '0;
         busy       <= 1'b0;
         upd_done   <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         div_done_q <= div_done;
         upd_done   <= 1'b0;
         // Any start edge outside IDLE (including DONE) is dropped and flagged.
         ovr        <= start && (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               busy <= start;
               if (start) begin
                  k1_q    <= $signed(k_1);
                  k2_q    <= $signed(k_2);
                  innov_q <= $signed(innov);
                  x1_q    <= $signed(x1_prior);
                  x2_q    <= $signed(x2_prior);
                  state_q <= S_MUL1;
               end
            end
            S_MUL1: begin
               prod_q  <= prod_d;
               state_q <= S_ACC1;
            end
            S_ACC1: begin
               x1_tmp_q <= x1_sat;
               state_q  <= S_MUL2;
            end
            S_MUL2: begin
               prod_q  <= prod_d;
               state_q <= S_ACC2;
            end
            S_ACC2: begin
               x2_tmp_q <= x2_sat;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               // busy stays high through the cycle upd_done is visible.
               x1_post  <= x1_tmp_q;
               x2_post  <= x2_tmp_q;
               upd_done <= 1'b1;
               busy     <= 1'b1;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
